// File: rtl/npxl_pkg.sv
// npxl_pkg: timing constants and receiver state encoding shared by the NeoPixel driver and receiver.
package npxl_pkg;
  localparam int T0H      = 19;
  localparam int T1H      = 38;
  localparam int TBIT     = 60;
  localparam int T_THRESH = 29;
  localparam int T_RESET  = 2400;
  localparam int BITS     = 24;
  typedef enum logic [2:0] {WAIT_RST, IDLE, HIGH, LOW, FWD, DISCARD} state_t;
  function automatic logic [23:0] grb_to_rgb(input logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction
endpackage

// File: rtl/npxl_flanken_sync.sv
// npxl_flanken_sync: 2-FF synchroniser for an asynchronous line plus registered rise/fall detect.
module npxl_flanken_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta, s, prev} <= '0;
    else {meta, s, prev} <= {d, meta, s};
  assign rise = s & ~prev;
  assign fall = ~s & prev;
endmodule

// File: rtl/npxl_empfaenger.sv
// npxl_empfaenger: WS2812-style receiver; captures the first BITS bits of a frame and forwards the rest.
// Define NPXL_RX_GRB_EN to present a G,R,B wire order as {R,G,B} on o_color_data.
module npxl_empfaenger
  import npxl_pkg::*;
#(
  parameter int T_MINH = 8,
  parameter int T_MAXH = 56
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_npxl_data,
  output logic [BITS-1:0] o_color_data,
  output logic            o_valid,
  output logic            o_npxl_fwd,
  output logic            o_busy,
  output logic            o_err
);
  localparam int LW = $clog2(T_RESET + 1);
  localparam int HW = $clog2(T_MAXH + 2);
  localparam int BW = $clog2(BITS + 1);
  logic s, rise, fall;
  state_t state, nxt;
  logic [LW-1:0] lcnt;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bitcnt;
  logic [BITS-2:0] sr;
  logic [BITS-1:0] sh, capt;
  logic tmo, over, bad, last, hbit, pend, pend_n, err_n, shift, done;

  npxl_flanken_sync u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_npxl_data),
    .s   (s),
    .rise(rise),
    .fall(fall)
  );

  assign tmo  = lcnt == LW'(T_RESET);
  assign hbit = hcnt >= HW'(T_THRESH);
  assign over = s && hcnt > HW'(T_MAXH);
  assign bad  = hcnt < HW'(T_MINH) || hcnt > HW'(T_MAXH);
  assign last = bitcnt == BW'(BITS - 1);
  assign sh   = {sr, hbit};
`ifdef NPXL_RX_GRB_EN
  assign capt = grb_to_rgb(sh);
`else
  assign capt = sh;
`endif
  assign o_busy = !(state inside {WAIT_RST, IDLE});

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= WAIT_RST;
    else state <= nxt;

  // a rise coinciding with the reset timeout is remembered in pend and starts the frame from IDLE
  always_comb begin
    nxt    = state;
    err_n  = 1'b0;
    shift  = 1'b0;
    done   = 1'b0;
    pend_n = tmo && rise && state != IDLE;
    case (state)
      WAIT_RST: nxt = tmo ? IDLE : WAIT_RST;
      IDLE:     nxt = (rise || pend) ? HIGH : IDLE;
      HIGH:
        if (over || (fall && bad)) begin
          err_n = 1'b1;
          nxt   = DISCARD;
        end else if (fall) begin
          shift = 1'b1;
          done  = last;
          nxt   = last ? FWD : LOW;
        end
      LOW:
        if (tmo) begin
          err_n = bitcnt != '0 && bitcnt < BW'(BITS);
          nxt   = IDLE;
        end else if (rise) nxt = HIGH;
      FWD, DISCARD: nxt = tmo ? IDLE : state;
      default: nxt = WAIT_RST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      lcnt         <= '0;
      hcnt         <= '0;
      bitcnt       <= '0;
      sr           <= '0;
      pend         <= 1'b0;
      o_color_data <= '0;
      o_valid      <= 1'b0;
      o_npxl_fwd   <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      lcnt         <= rise ? '0 : (!s && !tmo) ? lcnt + 1'b1 : lcnt;
      hcnt         <= rise ? HW'(1) : (s && hcnt <= HW'(T_MAXH)) ? hcnt + 1'b1 : hcnt;
      bitcnt       <= state == IDLE ? '0 : bitcnt + BW'(shift);
      sr           <= shift ? sh[BITS-2:0] : sr;
      pend         <= pend_n;
      o_color_data <= done ? capt : o_color_data;
      o_valid      <= done;
      o_npxl_fwd   <= state == FWD && s;
      o_err        <= err_n;
    end
endmodule

// File: tb/tb_npxl_empfaenger.sv
// tb_npxl_empfaenger: scoreboard bench for two chained receivers driven by a bench-side pulse generator.
`timescale 1ns/1ps
module tb_npxl_empfaenger;
  import npxl_pkg::*;
  logic clk = 0, rst = 0, line = 0;
  logic [23:0] col1, col2;
  logic val1, val2, fwd1, fwd2, busy1, busy2, err1, err2;
  int checks = 0, errors = 0;
  int nerr1 = 0, nerr2 = 0, nval1 = 0, nval2 = 0, fwd_rises = 0, fwd_bad = 0, e = 0;
  logic [23:0] q1[$], q2[$];
  logic [2:0] hist = '0;
  logic fwd_win = 0, fwd_prev = 0;

  always #10.4 clk = ~clk;

  npxl_empfaenger u1 (
    .i_clk(clk), .i_rst(rst), .i_npxl_data(line), .o_color_data(col1),
    .o_valid(val1), .o_npxl_fwd(fwd1), .o_busy(busy1), .o_err(err1)
  );
  npxl_empfaenger u2 (
    .i_clk(clk), .i_rst(rst), .i_npxl_data(fwd1), .o_color_data(col2),
    .o_valid(val2), .o_npxl_fwd(fwd2), .o_busy(busy2), .o_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_col(input logic [23:0] w);
`ifdef NPXL_RX_GRB_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic low(input int n);
    line = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int h, input int l);
    line = 1;
    repeat (h) @(negedge clk);
    line = 0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--)
      if (w[i]) send_bit(T1H, TBIT - T1H);
      else send_bit(T0H, TBIT - T0H);
  endtask

  always @(posedge clk) hist <= {hist[1:0], line};

  always @(negedge clk) begin
    if (val1) begin
      nval1++;
      if (q1.size() == 0) chk("spurious_valid1", val1, 0);
      else chk("color1", col1, q1.pop_front());
    end
    if (val2) begin
      nval2++;
      if (q2.size() == 0) chk("spurious_valid2", val2, 0);
      else chk("color2", col2, q2.pop_front());
    end
    if (err1) nerr1++;
    if (err2) nerr2++;
    if (fwd_win) begin
      if (fwd1 !== hist[2]) fwd_bad++;
      if (fwd1 && !fwd_prev) fwd_rises++;
    end
    fwd_prev = fwd1;
  end

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_color", col1, 0);
    chk("rst_valid", val1, 0);
    chk("rst_fwd", fwd1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_err", err1, 0);
    rst = 0;
    // line not yet idle for 50 us: frame must be ignored
    low(100);
    send_bits(24'hABCDEF, 24);
    low(2500);
    chk("wait_rst_valid", nval1, 0);
    chk("wait_rst_err", nerr1, 0);
    // five-LED chain
    q1.push_back(exp_col(24'h000700));
    q2.push_back(exp_col(24'h123456));
    send_bits(24'h000700, 24);
    fwd_win = 1;
    send_bits(24'h123456, 24);
    send_bits(24'h0000FF, 24);
    send_bits(24'hFF0000, 24);
    send_bits(24'h00FF00, 24);
    fwd_win = 0;
    low(2500);
    chk("chain_fwd_bits", fwd_rises, 96);
    chk("chain_fwd_lag", fwd_bad, 0);
    chk("chain_valid1", nval1, 1);
    chk("chain_valid2", nval2, 1);
    chk("chain_busy_end", busy1, 0);
    // alternating 19/38 highs
    q1.push_back(exp_col(24'h555555));
    send_bits(24'h555555, 24);
    low(2500);
    chk("alt_valid", nval1, 2);
    // partial frame of 10 bits
    e = nerr1;
    send_bits(24'hC3A5F0, 10);
    low(1000);
    chk("partial_busy", busy1, 1);
    chk("partial_no_err_yet", nerr1 - e, 0);
    low(2400);
    chk("partial_err", nerr1 - e, 1);
    chk("partial_no_valid", nval1, 2);
    chk("partial_color_kept", col1, exp_col(24'h555555));
    chk("partial_idle", busy1, 0);
    // glitch, then overlong high
    e = nerr1;
    send_bit(5, 20);
    chk("glitch_err", nerr1 - e, 1);
    chk("glitch_discard", busy1, 1);
    low(2500);
    chk("glitch_idle", busy1, 0);
    line = 1;
    repeat (65) @(negedge clk);
    chk("long_err", nerr1 - e, 2);
    chk("long_discard", busy1, 1);
    low(2500);
    chk("long_err_once", nerr1 - e, 2);
    // threshold and width boundaries: 8->0, 56->1, 28->0, 29->1
    q1.push_back(exp_col(24'h5A5C3E));
    send_bit(8, 52);
    send_bit(56, 4);
    send_bit(28, 32);
    send_bit(29, 31);
    send_bits({20'hA5C3E, 4'h0}, 20);
    low(2500);
    chk("bound_valid", nval1, 3);
    chk("bound_no_err", nerr1 - e, 2);
    // asynchronous reset mid-frame
    send_bits(24'hFFFFFF, 12);
    #3 rst = 1;
    #1;
    chk("arst_color", col1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_valid", val1, 0);
    chk("arst_fwd", fwd1, 0);
    chk("arst_err", err1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    e = nerr1;
    send_bits(24'h0F0F0F, 24);
    low(2500);
    chk("arst_ignored", nval1, 3);
    q1.push_back(exp_col(24'h2468AC));
    send_bits(24'h2468AC, 24);
    low(2500);
    chk("arst_accept", nval1, 4);
    chk("arst_no_err", nerr1 - e, 0);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    chk("rx2_err", nerr2, 0);
    chk("rx2_valid", nval2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npxl_empfaenger.md
Name: npxl_empfaenger

Overview:
- WS2812-style NeoPixel receiver: decodes the single-wire pulse-width stream produced by npxl_treiber, as a real LED would.
- Captures the first 24 bits of each frame into o_color_data and forwards all later bits on o_npxl_fwd to the next receiver in the chain.
- Used as a loopback/checker for the driver and as a chainable LED model in benches and on-chip self-test.
- Runs on the 48 MHz system clock, 20.8 ns period.

Parameters:
- T_THRESH, 29: high time in clocks at or above which a pulse decodes as 1, below as 0.
- T_MINH, 8: high pulses shorter than this are glitches and raise an error.
- T_MAXH, 56: high pulses longer than this raise an error.
- T_RESET, 2400: low time in clocks (50 us) that ends a frame (latch/reset).
- BITS, 24: bits captured per receiver.

Ports:
- i_clk  in  1  system clock, 48 MHz
- i_rst  in  1  asynchronous, active-high reset
- i_npxl_data  in  1  serial NeoPixel line, asynchronous to i_clk
- o_color_data  out  BITS  last captured colour word
- o_valid  out  1  one-cycle pulse when o_color_data is updated
- o_npxl_fwd  out  1  forwarded line for bits after the first BITS
- o_busy  out  1  high while a frame is in progress
- o_err  out  1  one-cycle pulse on a timing or frame error

Behaviour:
- Input path: 2-FF synchroniser, then an edge-detect register. All latencies below count from the synchronised signal s.
- Reset values: o_color_data=0, o_valid=0, o_npxl_fwd=0, o_busy=0, o_err=0, state=WAIT_RST, counters=0.
- Low counter (saturating at T_RESET) runs while s=0 and clears on a rising edge. High counter (saturating at T_MAXH+1) clears on a rising edge and counts while s=1.
- WAIT_RST: ignore edges until low count reaches T_RESET, then go to IDLE. Out of reset the line must be seen idle for 50 us before the first frame is accepted.
- IDLE: on a rising edge, go to HIGH, set o_busy=1, bitcnt=0.
- HIGH, on a falling edge:
  - if high count < T_MINH or > T_MAXH: o_err pulse, go to DISCARD;
  - otherwise shift bit (count >= T_THRESH) into the shift register MSB-first, bitcnt+1, go to LOW.
  - If high count exceeds T_MAXH while still high: o_err pulse immediately, go to DISCARD.
- Bit BITS completes: o_color_data updates and o_valid pulses on the cycle after that falling edge, then go to FWD.
- LOW:
  - rising edge returns to HIGH;
  - low count reaching T_RESET with 0 < bitcnt < BITS: o_err pulse, no o_valid, o_color_data unchanged, go to IDLE.
- FWD: o_npxl_fwd = s, registered, so it lags i_npxl_data by 3 cycles. When low count reaches T_RESET: o_npxl_fwd=0, go to IDLE.
- DISCARD: o_npxl_fwd=0; wait for low count to reach T_RESET, then go to IDLE.
- o_busy=1 in HIGH, LOW, FWD and DISCARD; 0 in IDLE and WAIT_RST.
- Simultaneous events: the T_RESET low timeout takes priority. An edge on the same cycle as the timeout starts a new frame from IDLE on the next cycle.
- Asynchronous i_rst mid-frame: immediate return to reset values; the partial frame is lost with no o_err.

Optional Feature:
- Macro NPXL_RX_GRB_EN.
- Defined: the wire order is G,R,B, and o_color_data is presented reordered as {R,G,B}.
- Undefined: o_color_data is the raw wire order, first received bit in the MSB.

Decomposition:
- Package npxl_pkg holds the timing constants shared with npxl_treiber: T0H=19, T1H=38, TBIT=60, T_THRESH, T_RESET, BITS.
- Package also holds the state enum: WAIT_RST, IDLE, HIGH, LOW, FWD, DISCARD.
- One sub-module: npxl_flanken_sync, the 2-FF synchroniser plus rise/fall detect, reusable by other line inputs.

Test Plan:
- Loopback from npxl_treiber, LEDS=5, colour 24'h000700: o_valid exactly once, o_color_data=24'h000700, and o_npxl_fwd carries 96 bits equal to the driver's output delayed 3 cycles.
- Two chained receivers on the same stream: second receiver reports LED 2's word, first reports LED 1's word.
- High pulses of 19 and 38 clocks alternating for 24 bits: o_color_data=24'h555555, since the first bit (19 clocks) decodes as 0 and the pattern gives 0101....
- Line low 1000 clocks after 10 bits, then low for 2400: o_err pulses once, no o_valid, o_color_data unchanged.
- 5-clock glitch, then a 70-clock high: each raises an o_err pulse with the state going to DISCARD; the next valid frame after 2400 low clocks decodes correctly.
- i_rst asserted at bit 12: all outputs 0 at once; the next frame is accepted only after 2400 low clocks.
- NPXL_RX_GRB_EN defined, wire word 24'h112233: o_color_data=24'h221133.
